// File: rtl/l32_pkg.sv
// l32_pkg: shared widths, slot geometry and FSM state types for the
// l32_decap_buffer egress store-and-forward buffer.
//   SLOT_IDX_W / PTR_W : slot index width and pointer width (index + wrap bit)
//   ADDR_W / OFF_W     : frame RAM address width and in-slot byte offset width
//   LEN_W              : stored frame length width (0..1024)
//   SKID_DEPTH         : output register plus two skid entries
package l32_pkg;

   localparam int SLOT_IDX_W = 3;
   localparam int PTR_W      = 4;
   localparam int ADDR_W     = 13;
   localparam int LEN_W      = 11;
   localparam int OFF_W      = 10;
   localparam int NUM_SLOTS  = 8;
   localparam int SLOT_BYTES = 1024;
   localparam int SKID_DEPTH = 3;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_WRITE = 2'd1,
      W_DROP  = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_FETCH  = 2'd1,
      R_STREAM = 2'd2
   } rd_state_e;

   // Byte address inside the frame RAM: slot index selects the 1 KiB slot.
   function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_IDX_W-1:0] idx,
                                                   input logic [OFF_W-1:0]      off);
      return {idx, off};
   endfunction

endpackage

// File: rtl/l32_frame_ram.sv
// l32_frame_ram: 8192 x 8 simple dual-port frame store.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request
//   rdata_o          : read data, registered, valid one cycle after re_i
module l32_frame_ram
   import l32_pkg::*;
(
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem_q [0:(1<<ADDR_W)-1];
   logic [7:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/l32_decap_buffer.sv
// l32_decap_buffer: egress store-and-forward buffer. Whole encapsulated
// frames are stored one per 1 KiB slot; committed frames are replayed with
// the first HDR_LEN bytes stripped. Errored, runt and oversize frames are
// discarded when their last byte arrives.
//   L32_clk, L32_rst_n        : clock, asynchronous active-low reset
//   L32i_t*                   : encapsulated input stream (tuser = frame error)
//   L32o_t*                   : decapsulated output stream
//   drop_cnt                  : saturating count of discarded frames
//   frames_pending            : committed frames not yet fully read out
module l32_decap_buffer
   import l32_pkg::*;
#(
   parameter int HDR_LEN = 38
)(
   input  logic        L32_clk,
   input  logic        L32_rst_n,
   input  logic [7:0]  L32i_tdata,
   input  logic        L32i_tvalid,
   input  logic        L32i_tlast,
   input  logic        L32i_tuser,
   output logic        L32i_tready,
   output logic [7:0]  L32o_tdata,
   output logic        L32o_tvalid,
   output logic        L32o_tlast,
   input  logic        L32o_tready,
   output logic [15:0] drop_cnt,
   output logic [3:0]  frames_pending
);

   localparam logic [LEN_W-1:0] HDR_L     = LEN_W'(HDR_LEN);
   localparam logic [OFF_W-1:0] HDR_OFF   = OFF_W'(HDR_LEN);
   localparam logic [LEN_W-1:0] SLOT_FULL = LEN_W'(SLOT_BYTES);

   // ---------------- slot pointers ----------------
   logic [PTR_W-1:0] wr_slot_q, wr_slot_d;
   logic [PTR_W-1:0] rd_slot_q, rd_slot_d;
   logic             full, empty;

   assign full  = (wr_slot_q[SLOT_IDX_W-1:0] == rd_slot_q[SLOT_IDX_W-1:0]) &&
                  (wr_slot_q[PTR_W-1] != rd_slot_q[PTR_W-1]);
   assign empty = (wr_slot_q == rd_slot_q);
   assign frames_pending = wr_slot_q - rd_slot_q;

   // ---------------- write side ----------------
   wr_state_e        wstate_q, wstate_d;
   logic [LEN_W-1:0] wcnt_q, wcnt_d;
   logic [15:0]      drop_q, drop_d;
   logic [LEN_W-1:0] len_q [NUM_SLOTS];
   logic [LEN_W-1:0] cnt_inc;
   logic             in_accept;
   logic             frame_good;
   logic             commit;
   logic             ram_we;
   logic [ADDR_W-1:0] ram_waddr;

   // Only a new frame is held off when full; a frame in progress always
   // owns a free slot, so it is never back-pressured.
   assign L32i_tready = (wstate_q != W_IDLE) || !full;
   assign in_accept   = L32i_tvalid && L32i_tready;
   assign cnt_inc     = wcnt_q + LEN_W'(1);
   assign drop_cnt    = drop_q;

   always_comb begin
      wstate_d   = wstate_q;
      wcnt_d     = wcnt_q;
      wr_slot_d  = wr_slot_q;
      drop_d     = drop_q;
      frame_good = 1'b0;
      commit     = 1'b0;
      ram_we     = 1'b0;
      ram_waddr  = slot_addr(wr_slot_q[SLOT_IDX_W-1:0], wcnt_q[OFF_W-1:0]);
      if (in_accept) begin
         case (wstate_q)
            W_IDLE, W_WRITE: begin
               // wcnt_q is 0 in W_IDLE, so the first byte lands at the slot base.
               if (wcnt_q == SLOT_FULL) begin
                  wstate_d = W_DROP;
               end else begin
                  ram_we     = 1'b1;
                  wcnt_d     = cnt_inc;
                  wstate_d   = W_WRITE;
                  frame_good = 1'b1;
               end
            end
            default: wstate_d = W_DROP;
         endcase
         if (L32i_tlast) begin
            commit = frame_good && !L32i_tuser && (cnt_inc > HDR_L);
            if (commit) begin
               wr_slot_d = wr_slot_q + PTR_W'(1);
            end else if (drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
            wstate_d = W_IDLE;
            wcnt_d   = '0;
         end
      end
   end

   always_ff @(posedge L32_clk or negedge L32_rst_n) begin
      if (!L32_rst_n) begin
         wstate_q  <= W_IDLE;
         wcnt_q    <= '0;
         wr_slot_q <= '0;
         drop_q    <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            len_q[i] <= '0;
         end
      end else begin
         wstate_q  <= wstate_d;
         wcnt_q    <= wcnt_d;
         wr_slot_q <= wr_slot_d;
         drop_q    <= drop_d;
         if (commit) begin
            len_q[wr_slot_q[SLOT_IDX_W-1:0]] <= cnt_inc;
         end
      end
   end

   // ---------------- read side ----------------
   rd_state_e        rstate_q, rstate_d;
   logic [OFF_W-1:0] roff_q, roff_d;      // next in-slot offset to fetch
   logic [LEN_W-1:0] rrem_q, rrem_d;      // payload bytes not yet fetched
   logic             infl_q, infl_last_q; // RAM read issued last cycle
   logic             ram_re, issue_last;
   logic [ADDR_W-1:0] ram_raddr;
   logic [7:0]       ram_rdata;
   logic [LEN_W-1:0] pay_len;

   // Shift-register FIFO: entry 0 is the output register, 1..2 are the skid.
   // Entries at or beyond occ_q are kept zero.
   logic [7:0]            sk_data_q [SKID_DEPTH];
   logic [7:0]            sk_data_d [SKID_DEPTH];
   logic [SKID_DEPTH-1:0] sk_last_q, sk_last_d;
   logic [1:0]            occ_q, occ_d, push_idx;
   logic                  valid_q;
   logic                  out_pop, rd_done;

   assign pay_len = len_q[rd_slot_q[SLOT_IDX_W-1:0]] - HDR_L;
   assign out_pop = valid_q && L32o_tready;
   assign rd_done = out_pop && sk_last_q[0];

   always_comb begin
      rstate_d   = rstate_q;
      roff_d     = roff_q;
      rrem_d     = rrem_q;
      rd_slot_d  = rd_slot_q;
      ram_re     = 1'b0;
      issue_last = 1'b0;
      ram_raddr  = slot_addr(rd_slot_q[SLOT_IDX_W-1:0], roff_q);
      case (rstate_q)
         R_IDLE: begin
            if (!empty) begin
               ram_re     = 1'b1;
               ram_raddr  = slot_addr(rd_slot_q[SLOT_IDX_W-1:0], HDR_OFF);
               issue_last = (pay_len == LEN_W'(1));
               roff_d     = HDR_OFF + OFF_W'(1);
               rrem_d     = pay_len - LEN_W'(1);
               rstate_d   = R_FETCH;
            end
         end
         R_FETCH, R_STREAM: begin
            // Prefetch while held bytes plus the one in flight leave room.
            if ((rrem_q != '0) && (({1'b0, occ_q} + {2'b00, infl_q}) < 3'd3)) begin
               ram_re     = 1'b1;
               issue_last = (rrem_q == LEN_W'(1));
               roff_d     = roff_q + OFF_W'(1);
               rrem_d     = rrem_q - LEN_W'(1);
            end
            if (rstate_q == R_FETCH) begin
               rstate_d = R_STREAM;
            end else if (rd_done) begin
               rstate_d  = R_IDLE;
               rd_slot_d = rd_slot_q + PTR_W'(1);
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
         sk_data_d[i] = sk_data_q[i];
      end
      sk_last_d = sk_last_q;
      push_idx  = occ_q - {1'b0, out_pop};
      if (out_pop) begin
         for (int i = 0; i < SKID_DEPTH-1; i++) begin
            sk_data_d[i] = sk_data_q[i+1];
         end
         sk_data_d[SKID_DEPTH-1] = '0;
         sk_last_d = {1'b0, sk_last_q[SKID_DEPTH-1:1]};
      end
      if (infl_q) begin
         sk_data_d[push_idx] = ram_rdata;
         sk_last_d[push_idx] = infl_last_q;
      end
      occ_d = occ_q + {1'b0, infl_q} - {1'b0, out_pop};
   end

   always_ff @(posedge L32_clk or negedge L32_rst_n) begin
      if (!L32_rst_n) begin
         rstate_q    <= R_IDLE;
         roff_q      <= '0;
         rrem_q      <= '0;
         rd_slot_q   <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         occ_q       <= '0;
         valid_q     <= 1'b0;
         sk_last_q   <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            sk_data_q[i] <= '0;
         end
      end else begin
         rstate_q    <= rstate_d;
         roff_q      <= roff_d;
         rrem_q      <= rrem_d;
         rd_slot_q   <= rd_slot_d;
         infl_q      <= ram_re;
         infl_last_q <= issue_last;
         occ_q       <= occ_d;
         valid_q     <= (occ_d != 2'd0);
         sk_last_q   <= sk_last_d;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            sk_data_q[i] <= sk_data_d[i];
         end
      end
   end

   assign L32o_tdata  = sk_data_q[0];
   assign L32o_tlast  = sk_last_q[0];
   assign L32o_tvalid = valid_q;

   l32_frame_ram u_ram (
      .clk_i   (L32_clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (L32i_tdata),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_l32_decap_buffer.sv
// Self-checking bench for l32_decap_buffer. The reference model keeps a
// queue of expected output bytes per frame and a drop counter, derived
// directly from the frame rules (length window, error flag, header strip).
module tb_l32_decap_buffer;

   localparam int HDR = 38;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  L32i_tdata = '0;
   logic        L32i_tvalid = 1'b0;
   logic        L32i_tlast = 1'b0;
   logic        L32i_tuser = 1'b0;
   logic        L32i_tready;
   logic [7:0]  L32o_tdata;
   logic        L32o_tvalid;
   logic        L32o_tlast;
   logic        L32o_tready;
   logic [15:0] drop_cnt;
   logic [3:0]  frames_pending;

   always #5 clk = ~clk;

   l32_decap_buffer #(.HDR_LEN(HDR)) dut (
      .L32_clk        (clk),
      .L32_rst_n      (rst_n),
      .L32i_tdata     (L32i_tdata),
      .L32i_tvalid    (L32i_tvalid),
      .L32i_tlast     (L32i_tlast),
      .L32i_tuser     (L32i_tuser),
      .L32i_tready    (L32i_tready),
      .L32o_tdata     (L32o_tdata),
      .L32o_tvalid    (L32o_tvalid),
      .L32o_tlast     (L32o_tlast),
      .L32o_tready    (L32o_tready),
      .drop_cnt       (drop_cnt),
      .frames_pending (frames_pending)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_data [$];
   bit          exp_last [$];
   int          exp_drops = 0;
   int          rx_count = 0;
   int          rdy_mode = 0;   // 0: always ready, 1: never, 2: random 50%
   int          last_stalls = 0;
   bit          prev_stall = 1'b0;
   logic [9:0]  prev_out = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Output ready generator.
   initial begin
      L32o_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1:       L32o_tready = 1'b0;
            2:       L32o_tready = 1'($urandom_range(1));
            default: L32o_tready = 1'b1;
         endcase
      end
   end

   // Output monitor: scoreboard plus AXI-Stream hold rule.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            assert ({L32o_tvalid, L32o_tlast, L32o_tdata} === prev_out) else begin
               errors++;
               $error("FAIL hold_rule observed=%0h expected=%0h",
                      {L32o_tvalid, L32o_tlast, L32o_tdata}, prev_out);
            end
         end
         if (L32o_tvalid && L32o_tready) begin
            checks++;
            assert (exp_data.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_byte observed=%0h expected=none", L32o_tdata);
            end
            if (exp_data.size() != 0) begin
               logic [7:0] ed;
               bit         el;
               ed = exp_data.pop_front();
               el = exp_last.pop_front();
               checks++;
               assert ({L32o_tlast, L32o_tdata} === {el, ed}) else begin
                  errors++;
                  $error("FAIL out_byte observed=%0h expected=%0h",
                         {L32o_tlast, L32o_tdata}, {el, ed});
               end
            end
            rx_count++;
         end
         prev_stall = L32o_tvalid && !L32o_tready;
         prev_out   = {L32o_tvalid, L32o_tlast, L32o_tdata};
      end
   end

   // Sends one frame of random bytes; called and returns at posedge+1.
   task automatic send_frame(input int len, input bit user, input bit truncate, input int gap_pct);
      logic [7:0] d [$];
      int         stalls = 0;
      bit         legal;
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      legal = !truncate && !user && (len > HDR) && (len <= 1024);
      if (legal) begin
         for (int i = HDR; i < len; i++) begin
            exp_data.push_back(d[i]);
            exp_last.push_back(i == len - 1);
         end
      end else if (!truncate && exp_drops < 65535) begin
         exp_drops++;
      end
      $display("frame len=%0d user=%0d truncated=%0d -> %s", len, user, truncate,
               truncate ? "partial" : (legal ? "forward" : "drop"));
      for (int i = 0; i < len; i++) begin
         if (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
            L32i_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         L32i_tdata  = d[i];
         L32i_tvalid = 1'b1;
         L32i_tlast  = !truncate && (i == len - 1);
         L32i_tuser  = L32i_tlast && user;
         while (!L32i_tready && stalls < 5000) begin
            @(posedge clk); #1;
            stalls++;
         end
         if (!L32i_tready) begin
            chk("in_tready_timeout", 32'(L32i_tready), 32'd1);
            break;
         end
         @(posedge clk); #1;
      end
      L32i_tvalid = 1'b0;
      L32i_tlast  = 1'b0;
      L32i_tuser  = 1'b0;
      last_stalls = stalls;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_data.size() != 0 && n < 40000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_remaining"}, 32'(exp_data.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_pending"}, 32'(frames_pending), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_tready"}, 32'(L32i_tready), 32'd1);
      chk({tag, "_tvalid"}, 32'(L32o_tvalid), 32'd0);
      chk({tag, "_tlast"}, 32'(L32o_tlast), 32'd0);
      chk({tag, "_tdata"}, 32'(L32o_tdata), 32'd0);
      chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
      chk({tag, "_pending"}, 32'(frames_pending), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single 100-byte frame, latency and content
      base = rx_count;
      chk("t1_pending_before", 32'(frames_pending), 32'd0);
      send_frame(100, 1'b0, 1'b0, 0);
      chk("t1_pending_commit", 32'(frames_pending), 32'd1);
      chk("t1_tvalid_n1", 32'(L32o_tvalid), 32'd0);
      @(posedge clk); #1;
      chk("t1_tvalid_n2", 32'(L32o_tvalid), 32'd0);
      @(posedge clk); #1;
      chk("t1_tvalid_n3", 32'(L32o_tvalid), 32'd1);
      drain("t1");
      chk("t1_bytes", 32'(rx_count - base), 32'd62);

      // 2: runt at exactly HDR bytes, then an errored frame
      base = rx_count;
      send_frame(38, 1'b0, 1'b0, 0);
      send_frame(100, 1'b1, 1'b0, 0);
      repeat (30) @(posedge clk);
      #1;
      chk("t2_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
      chk("t2_bytes", 32'(rx_count - base), 32'd0);
      chk("t2_pending", 32'(frames_pending), 32'd0);

      // 3: oversize frame never stalls, then slot-size edge cases
      base = rx_count;
      send_frame(1100, 1'b0, 1'b0, 0);
      chk("t3_oversize_stalls", 32'(last_stalls), 32'd0);
      send_frame(64, 1'b0, 1'b0, 0);
      drain("t3a");
      chk("t3_bytes_64", 32'(rx_count - base), 32'd26);
      base = rx_count;
      send_frame(1024, 1'b0, 1'b0, 0);
      send_frame(1025, 1'b0, 1'b0, 0);
      send_frame(39, 1'b0, 1'b0, 0);
      drain("t3b");
      chk("t3_bytes_edges", 32'(rx_count - base), 32'd987);
      chk("t3_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

      // 4: fill all slots with output stalled, then release
      base = rx_count;
      rdy_mode = 1;
      @(posedge clk); #1;
      for (int f = 0; f < 8; f++) send_frame(64, 1'b0, 1'b0, 0);
      chk("t4_full_tready", 32'(L32i_tready), 32'd0);
      chk("t4_full_pending", 32'(frames_pending), 32'd8);
      fork
         send_frame(64, 1'b0, 1'b0, 0);
         begin
            int n = 0;
            repeat (6) @(posedge clk);
            #1;
            chk("t4_still_full", 32'(L32i_tready), 32'd0);
            chk("t4_still_pending", 32'(frames_pending), 32'd8);
            rdy_mode = 0;
            while (frames_pending == 4'd8 && n < 500) begin
               @(posedge clk); #1;
               n++;
            end
            chk("t4_freed_pending", 32'(frames_pending), 32'd7);
            chk("t4_freed_tready", 32'(L32i_tready), 32'd1);
         end
      join
      drain("t4");
      chk("t4_bytes", 32'(rx_count - base), 32'd234);

      // 5: random lengths with random output backpressure
      base = rx_count;
      rdy_mode = 2;
      for (int f = 0; f < 20; f++) begin
         send_frame(int'($urandom_range(1024, 39)), 1'b0, 1'b0, 10);
      end
      drain("t5");
      chk("t5_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

      // 6: reset mid-input and mid-output
      rdy_mode = 1;
      @(posedge clk); #1;
      send_frame(100, 1'b0, 1'b0, 0);
      repeat (5) @(posedge clk);
      #1;
      send_frame(20, 1'b0, 1'b1, 0);
      rdy_mode = 2;
      repeat (10) @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_reset_values("midreset");
      exp_data.delete();
      exp_last.delete();
      exp_drops = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 0;
      @(posedge clk); #1;
      base = rx_count;
      send_frame(50, 1'b0, 1'b0, 0);
      drain("t6");
      chk("t6_bytes", 32'(rx_count - base), 32'd12);
      chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l32_decap_buffer.md
# l32_decap_buffer

Egress-side store-and-forward buffer that is the counterpart of the L2→L3 encapsulating ingress buffer: it accepts encapsulated frames on an AXI-Stream byte interface, stores each whole frame in one of 8 fixed 1 KiB slots of an 8 KiB RAM, strips a fixed-length tunnel header, and replays only the inner L2 frame on the output stream. Errored, runt and oversize frames are discarded at commit time and counted. It sits between the tunnel-side receive path and the L2 transmit MAC.

## Interface
- HDR_LEN, 38, encapsulation header bytes stripped per frame (Ethernet 14 + IPv4 20 + GRE 4); legal range 1..1000
- SLOT_BYTES, 1024, bytes per slot; fixed power of two, 8 slots → 13-bit RAM address
- L32_clk  in  1  sole clock, all logic rising-edge
- L32_rst_n  in  1  reset, asynchronous assert, active-low
- L32i_tdata  in  8  encapsulated frame byte
- L32i_tvalid  in  1  input byte valid
- L32i_tlast  in  1  last byte of input frame
- L32i_tuser  in  1  frame error, sampled only with tlast
- L32i_tready  out  1  buffer accepts input byte
- L32o_tdata  out  8  decapsulated frame byte
- L32o_tvalid  out  1  output byte valid
- L32o_tlast  out  1  last byte of output frame
- L32o_tready  in  1  downstream accepts output byte
- drop_cnt  out  16  frames discarded since reset, saturates at 0xFFFF
- frames_pending  out  4  committed frames not yet fully read (0..8)

## Operation
- Slot pointers: wr_slot, rd_slot 4 bits each (3-bit index + wrap bit); full when indices equal and wrap bits differ, empty when equal. frames_pending = wr_slot − rd_slot (mod 16).
- Write FSM W_IDLE / W_WRITE / W_DROP:
  - W_IDLE: L32i_tready = !full. First accepted byte → W_WRITE, byte written at {wr_slot[2:0], 10'd0}, byte count = 1.
  - W_WRITE: tready = 1. Each accepted byte written at slot base + count, count++. 1025th byte → W_DROP (byte not written).
  - W_DROP: tready = 1, bytes discarded until tlast.
  - Accepted tlast: commit if tuser = 0, state was W_WRITE, and final count > HDR_LEN; commit stores length[wr_slot] = count (11 bits) and increments wr_slot. Otherwise drop_cnt++ (saturating), slot reused. Always → W_IDLE.
  - Single-byte frame (tlast on first byte) handled identically (count = 1 → runt drop).
- Read FSM R_IDLE / R_FETCH / R_STREAM:
  - R_IDLE: if !empty → R_FETCH, read address = slot base + HDR_LEN, remaining = length − HDR_LEN.
  - R_FETCH: one RAM latency cycle; data lands in output register, → R_STREAM.
  - R_STREAM: output register holds current byte; 2-entry skid register keeps 1 byte/cycle under backpressure with RAM prefetch. L32o_tlast with the byte where remaining = 1. Accepted tlast → rd_slot++, → R_IDLE.
- Output bytes never change while tvalid & !tready (AXI-Stream hold rule).
- Simultaneous commit and read-complete in one cycle: both pointers update; frames_pending unchanged.
- Reset mid-frame: all pointers, lengths-valid, FSMs, counters cleared; partial frames lost, no output glitch beyond forced-low tvalid.

## Timing
- Reset values: L32i_tready 1, L32o_tvalid 0, L32o_tlast 0, L32o_tdata 0, drop_cnt 0, frames_pending 0.
- All outputs driven from registers; no combinational input→output path.
- Commit visible (frames_pending increments) one cycle after the accepting edge of tlast (cycle N+1).
- Reader idle and buffer previously empty: first L32o_tvalid at cycle N+3.
- Streaming: 1 byte/cycle with L32o_tready high; exactly 2 idle cycles (R_IDLE, R_FETCH) between back-to-back output frames.
- Full: L32i_tready drops the cycle after the 8th commit; rises the cycle after the read pointer frees a slot.

## Structure
- Package l32_pkg: SLOT_IDX_W = 3, PTR_W = 4, ADDR_W = 13, LEN_W = 11, write and read state enums.
- Sub-module l32_frame_ram: 8192×8 simple dual-port RAM, one write port, one read port with registered output (1-cycle latency), inferable as block RAM.
- Length array (8×11) and pointer logic stay in the top.

## Test plan
- Single 100-byte frame, tuser 0, output tready 1 → 62 bytes out equal to input bytes 38..99, tlast on 62nd, first tvalid at N+3.
- Frame of 38 bytes, then frame with tuser 1 at tlast → no output, drop_cnt = 2.
- 1100-byte frame → tready stays high through all 1100 bytes, no output, drop_cnt = 1, next 64-byte frame yields 26 bytes.
- 9 back-to-back 64-byte frames, output tready 0 → tready low after 8th commit, frames_pending = 8; release tready → 8×26 bytes, then 9th accepted.
- Random output tready (50%) over 20 frames of 39..1024 bytes → byte-exact output, no data change while stalled, final frames_pending 0.
- Reset asserted mid-input and mid-output → all outputs at reset values asynchronously; subsequent 50-byte frame produces 12 correct bytes.
